fetch_unit: RTL

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the word-aligned fetch address into the synchronous-read instruction memory, which returns data one cycle later. It captures the returned instruction together with its PC and presents both to the decode stage over a valid/ready handshake. A small skid FIFO absorbs decode back-pressure without losing in-flight reads. Branch/jump redirects flush all stale work.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 69 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the {pc, inst} entry type for the fetch stage
package fetch_pkg;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: skid FIFO of fetched {pc, inst} entries
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write;
// i_pop removes head; i_flush empties (wins over push/pop); o_head/o_count state.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign o_head = mem[rd_ptr];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_count <= '0;
        end else begin
            rd_ptr  <= i_pop ? nxt(rd_ptr) : rd_ptr;
            wr_ptr  <= i_push ? nxt(wr_ptr) : wr_ptr;
            o_count <= o_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem[wr_ptr] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory request and decode handshake
// Ports: i_clk/i_rst_n clock and async active-low reset; o_imem_addr/i_imem_data
// synchronous-read memory (data one cycle after address); i_redirect_valid/pc
// branch target; i_halt stops new fetches; o_inst_valid/i_dec_ready/o_inst/
// o_inst_pc decode handshake; o_idle halted and fully drained.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_inst_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_idle
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   fetch_pc, req_pc;
    logic          req_valid, has_entry, pop, issue, push;
    logic [CW:0]   occ;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    assign has_entry    = count != '0;
    assign o_inst_valid = (has_entry | req_valid) & ~i_redirect_valid;
    assign pop          = o_inst_valid & i_dec_ready;
    // Slots committed after this cycle: buffered + in flight - leaving now.
    assign occ          = {1'b0, count} + (CW+1)'(req_valid) - (CW+1)'(pop);
    assign issue        = ~i_halt & ~i_redirect_valid & (occ < (CW+1)'(DEPTH));
    // The returning word is buffered unless the bypass path hands it to decode.
    assign push         = req_valid & ~i_redirect_valid & ~(pop & ~has_entry);
    assign o_imem_addr  = fetch_pc;
    assign o_inst       = !o_inst_valid ? 32'h0 : has_entry ? head.inst : i_imem_data;
    assign o_inst_pc    = !o_inst_valid ? 32'h0 : has_entry ? head.pc : req_pc;
    assign o_idle       = i_halt & ~req_valid & ~has_entry;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop & has_entry),
        .i_flush (i_redirect_valid),
        .i_data  ('{pc: req_pc, inst: i_imem_data}),
        .o_head  (head),
        .o_count (count)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc  <= RESET_PC & ~32'h3;
            req_pc    <= '0;
            req_valid <= 1'b0;
        end else if (i_redirect_valid) begin
            fetch_pc  <= i_redirect_pc & ~32'h3;
            req_valid <= 1'b0;
        end else begin
            req_valid <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end
endmodule
